monolith_perm_ctrl: RTL and testbench
=====================================

MONOLITH_PERM_CTRL -- requirements
Module: monolith_perm_ctrl

Interface
REQ-001 SHALL have parameter NUM_ROUNDS, default 6, number of round-core invocations per permutation (legal 1..8).
REQ-002 SHALL have port clk  in  1  single clock, all logic on rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have ports in_valid in 1, in_ready out 1, in_data in 31: serial state-word load stream.
REQ-005 SHALL have ports out_valid out 1, out_ready in 1, out_data out 31, out_last out 1: serial result stream.
REQ-006 SHALL have ports rnd_start out 1, rnd_index out 3, rnd_state_in out 16x31: round-core command.
REQ-007 SHALL have ports rnd_valid in 1, rnd_state_out in 16x31: round-core result.
REQ-008 SHALL have port busy  out 1  high in every state except LOAD.

Function
REQ-009 SHALL implement FSM states LOAD, START, WAIT, DRAIN; reset state LOAD.
REQ-010 LOAD: in_ready=1; word accepted when in_valid&&in_ready; stored to state[load_idx], load_idx 0..15 increments per accept.
REQ-011 Accepted in_data == 0x7FFFFFFF SHALL be stored as 0 (reduction mod p=2^31-1); all other values stored unchanged.
REQ-012 Accept of word 15 -> START next cycle; in_valid gaps SHALL stall load without loss.
REQ-013 START: rnd_start=1 for exactly one cycle, rnd_state_in=state, rnd_index=round counter; next state WAIT.
REQ-014 rnd_state_in and rnd_index SHALL stay stable from START until rnd_valid accepted in WAIT.
REQ-015 WAIT: on rnd_valid, state <= rnd_state_out; if round==NUM_ROUNDS-1 -> DRAIN, else round++ and -> START.
REQ-016 rnd_valid in any state other than WAIT SHALL be ignored (no state/data change).
REQ-017 Latency: last-word accept -> rnd_start 1 cycle; rnd_valid -> next rnd_start 1 cycle; final rnd_valid -> out_valid 1 cycle.
REQ-018 DRAIN: out_valid=1, out_data=state[out_idx]; out_idx advances only on out_valid&&out_ready; data held stable under backpressure.
REQ-019 out_last=1 exactly while out_idx==15 in DRAIN.
REQ-020 Accept of word 15 in DRAIN -> LOAD next cycle, round and indices cleared; in_ready=0 in START/WAIT/DRAIN.
REQ-021 Round counter width 3 bits; SHALL never wrap during a permutation.

Reset
REQ-022 Assertion of reset SHALL immediately (no clock) force state LOAD, indices/round=0, rnd_start=0, out_valid=0, out_last=0, busy=0, rnd_index=0, out_data=0.
REQ-023 in_ready SHALL be 0 while reset asserted, 1 from first clk after release.
REQ-024 Reset mid-operation SHALL abandon the permutation; stale rnd_valid afterwards ignored per REQ-016.
REQ-025 state storage need not be cleared by reset; it is fully overwritten before use.

Structure
REQ-026 Shared package monolith_pkg SHALL hold P=31'h7FFFFFFF, ELEM_W=31, STATE_W=16, elem_t, state_t (16 x elem_t), ctrl FSM enum.
REQ-027 No sub-module required; monolith_round is instantiated beside this block at top level, not inside it.
REQ-028 Bench SHALL use a round stub: each element +1 mod P, rnd_valid 3 cycles after rnd_start.

Verification
REQ-029 Load 0..15, NUM_ROUNDS=6, out_ready=1 -> out 6..21 in order, out_last on 21, six rnd_start pulses with rnd_index 0..5.
REQ-030 Load word0=0x7FFFFFFF, word1=0x7FFFFFFE, rest 0 -> out 6, 5, then 6 x14.
REQ-031 out_ready pattern 1,0,1,0... -> each out_data held while out_ready=0, 16 words in order, in_ready=0 until word 15 accepted.
REQ-032 in_valid toggling 1,0 during load -> 16 words captured correctly; rnd_start 1 cycle after 16th accept.
REQ-033 Reset asserted in WAIT of round 3 -> outputs per REQ-022 without clock; stub's late rnd_valid ignored; next load completes with 6 rounds.
REQ-034 rnd_valid pulsed in LOAD and DRAIN -> no change to stored state, out_data or FSM.

Source files
------------

// File: rtl/monolith_pkg.sv
// Shared types and constants for the Monolith permutation controller and round core.
package monolith_pkg;

   localparam int unsigned ELEM_W  = 31;
   localparam int unsigned STATE_W = 16;
   localparam int unsigned IDX_W   = 4;
   localparam int unsigned RND_W   = 3;

   localparam logic [ELEM_W-1:0] P = 31'h7FFFFFFF;

   typedef logic [ELEM_W-1:0] elem_t;
   typedef elem_t [STATE_W-1:0] state_t;

   typedef enum logic [1:0] {
      LOAD  = 2'd0,
      START = 2'd1,
      WAIT  = 2'd2,
      DRAIN = 2'd3
   } ctrl_state_e;

   // Canonical representative mod p: the only non-canonical 31-bit value is p itself.
   function automatic elem_t reduce_p(input elem_t x);
      return (x == P) ? '0 : x;
   endfunction

endpackage

// File: rtl/monolith_perm_ctrl.sv
// Sequences NUM_ROUNDS round-core invocations over a 16-word state loaded and
// drained through serial valid/ready streams.
module monolith_perm_ctrl
   import monolith_pkg::*;
#(
   parameter int unsigned NUM_ROUNDS = 6
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  elem_t             in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output elem_t             out_data,
   output logic              out_last,
   output logic              rnd_start,
   output logic [RND_W-1:0]  rnd_index,
   output state_t            rnd_state_in,
   input  logic              rnd_valid,
   input  state_t            rnd_state_out,
   output logic              busy
);

   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(STATE_W - 1);
   localparam logic [RND_W-1:0] LAST_RND  = RND_W'(NUM_ROUNDS - 1);

   ctrl_state_e       fsm_q, fsm_nx;
   state_t            st_q, st_nx;
   logic [IDX_W-1:0]  load_idx_q, load_idx_nx;
   logic [IDX_W-1:0]  out_idx_q, out_idx_nx;
   logic [RND_W-1:0]  round_q, round_nx;

   // Next-state, datapath and index updates.
   always_comb begin
      fsm_nx      = fsm_q;
      st_nx       = st_q;
      load_idx_nx = load_idx_q;
      out_idx_nx  = out_idx_q;
      round_nx    = round_q;
      case (fsm_q)
         LOAD: begin
            if (in_valid && in_ready) begin
               st_nx[load_idx_q] = reduce_p(in_data);
               if (load_idx_q == LAST_IDX) begin
                  load_idx_nx = '0;
                  fsm_nx      = START;
               end else begin
                  load_idx_nx = load_idx_q + IDX_W'(1);
               end
            end
         end
         START: begin
            fsm_nx = WAIT;
         end
         WAIT: begin
            if (rnd_valid) begin
               st_nx = rnd_state_out;
               if (round_q == LAST_RND) begin
                  fsm_nx = DRAIN;
               end else begin
                  round_nx = round_q + RND_W'(1);
                  fsm_nx   = START;
               end
            end
         end
         DRAIN: begin
            if (out_valid && out_ready) begin
               if (out_idx_q == LAST_IDX) begin
                  out_idx_nx = '0;
                  round_nx   = '0;
                  fsm_nx     = LOAD;
               end else begin
                  out_idx_nx = out_idx_q + IDX_W'(1);
               end
            end
         end
         default: begin
            fsm_nx = LOAD;
         end
      endcase
   end

   // Control state and registered outputs, all decoded from the next state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fsm_q      <= LOAD;
         load_idx_q <= '0;
         out_idx_q  <= '0;
         round_q    <= '0;
         in_ready   <= 1'b0;
         busy       <= 1'b0;
         rnd_start  <= 1'b0;
         out_valid  <= 1'b0;
         out_last   <= 1'b0;
         out_data   <= '0;
      end else begin
         fsm_q      <= fsm_nx;
         load_idx_q <= load_idx_nx;
         out_idx_q  <= out_idx_nx;
         round_q    <= round_nx;
         in_ready   <= (fsm_nx == LOAD);
         busy       <= (fsm_nx != LOAD);
         rnd_start  <= (fsm_nx == START);
         out_valid  <= (fsm_nx == DRAIN);
         out_last   <= (fsm_nx == DRAIN) && (out_idx_nx == LAST_IDX);
         out_data   <= (fsm_nx == DRAIN) ? st_nx[out_idx_nx] : '0;
      end
   end

   // State words are always fully rewritten by a load before use, so no reset.
   always_ff @(posedge clk) begin
      st_q <= st_nx;
   end

   assign rnd_state_in = st_q;
   assign rnd_index    = round_q;

endmodule

// File: tb/tb_monolith_perm_ctrl.sv
// Scoreboard bench for monolith_perm_ctrl with a +1 mod p round-core stub.
module tb_monolith_perm_ctrl;
   import monolith_pkg::*;

   localparam int unsigned NR    = 6;
   localparam int          LIMIT = 800;

   logic        clk       = 1'b0;
   logic        reset     = 1'b1;
   logic        in_valid  = 1'b0;
   logic        in_ready;
   elem_t       in_data   = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   elem_t       out_data;
   logic        out_last;
   logic        rnd_start;
   logic [2:0]  rnd_index;
   state_t      rnd_state_in;
   logic        rnd_valid;
   state_t      rnd_state_out;
   logic        busy;

   int checks = 0;
   int errors = 0;

   elem_t exp_q[$];
   bit    last_q[$];

   always #5 clk = ~clk;

   monolith_perm_ctrl #(.NUM_ROUNDS(NR)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
      .rnd_start(rnd_start), .rnd_index(rnd_index), .rnd_state_in(rnd_state_in),
      .rnd_valid(rnd_valid), .rnd_state_out(rnd_state_out), .busy(busy)
   );

   task automatic chk(input string name, input longint act, input longint req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
      end
   endtask

   // ---------------- round-core stub: +1 mod p, answer 3 cycles after start
   function automatic state_t stub_round(input state_t s);
      state_t r;
      for (int k = 0; k < 16; k++) r[k] = elem_t'((longint'(s[k]) + 1) % longint'(P));
      return r;
   endfunction

   logic [2:0] sv = '0;
   state_t     sd0, sd1, sd2;
   logic [2:0] si0 = '0, si1 = '0, si2 = '0;
   logic       spur_l = 1'b0, spur_d = 1'b0;
   state_t     spur_data;

   always @(posedge clk) begin
      sv  <= {sv[1:0], rnd_start};
      sd0 <= stub_round(rnd_state_in);
      sd1 <= sd0;
      sd2 <= sd1;
      si0 <= rnd_index;
      si1 <= si0;
      si2 <= si1;
   end

   assign rnd_valid     = sv[2] | spur_l | spur_d;
   assign rnd_state_out = sv[2] ? sd2 : spur_data;

   // ---------------- reference model: value mod p plus one per round
   function automatic elem_t ref_out(input elem_t w);
      longint v;
      v = longint'(w) % longint'(P);
      v = (v + longint'(NR)) % longint'(P);
      return elem_t'(v);
   endfunction

   // ---------------- output-ready driver and DRAIN-time spurious rnd_valid
   int or_mode   = 0;
   bit spur_dren = 1'b0;
   always @(posedge clk) begin
      #1;
      case (or_mode)
         0:       out_ready = 1'b1;
         1:       out_ready = ~out_ready;
         default: out_ready = 1'($urandom_range(0, 1));
      endcase
      spur_d = spur_dren && out_valid && ($urandom_range(0, 3) == 0);
   end

   // ---------------- monitor
   bit    hold_p = 1'b0;
   elem_t held;
   bit    held_last;
   bit    exp_rs = 1'b0, exp_ov = 1'b0;
   bit    suppress = 1'b0;
   int    pulses = 0;
   int    exp_idx = 0;

   always @(negedge clk) begin
      if (!reset) begin
         if (exp_rs) chk("rnd_start_after_valid", rnd_start, 1);
         if (exp_ov) chk("out_valid_after_final", out_valid, 1);
         exp_rs = sv[2] && !suppress && (si2 != 3'(NR - 1));
         exp_ov = sv[2] && !suppress && (si2 == 3'(NR - 1));
         if (sv[2] && !suppress) chk("rnd_index_stable", rnd_index, si2);
         if (rnd_start) begin
            chk("rnd_index", rnd_index, exp_idx);
            exp_idx = (exp_idx + 1) % NR;
            pulses++;
         end
         if (out_valid) begin
            chk("in_ready_in_drain", in_ready, 0);
            if (hold_p) begin
               chk("hold_data", out_data, held);
               chk("hold_last", out_last, held_last);
            end
            if (out_ready) begin
               hold_p = 1'b0;
               if (exp_q.size() == 0) begin
                  chk("unexpected_output", 1, 0);
               end else begin
                  elem_t e;
                  bit    l;
                  e = exp_q.pop_front();
                  l = last_q.pop_front();
                  chk("out_data", out_data, e);
                  chk("out_last", out_last, l);
                  if (l) begin
                     chk("rounds_per_perm", pulses, NR);
                     pulses = 0;
                  end
               end
            end else begin
               hold_p    = 1'b1;
               held      = out_data;
               held_last = out_last;
            end
         end
      end
   end

   // ---------------- load driver
   task automatic load_perm(input elem_t w[16], input bit gap, input bit spur);
      int i   = 0;
      int n   = 0;
      bit tog = 1'b0;
      while (i < 16) begin
         @(posedge clk); #1;
         spur_l = 1'b0;
         if (n > LIMIT) begin
            chk("load_timeout", n, 0);
            in_valid = 1'b0;
            return;
         end
         n++;
         tog = ~tog;
         if (gap && !tog) begin
            in_valid = 1'b0;
         end else begin
            in_valid = 1'b1;
            in_data  = w[i];
         end
         if (spur && i == 5) spur_l = 1'b1;
         @(negedge clk);
         if (in_valid && in_ready) i++;
      end
      for (int k = 0; k < 16; k++) begin
         exp_q.push_back(ref_out(w[k]));
         last_q.push_back(k == 15);
      end
      suppress = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      spur_l   = 1'b0;
      @(negedge clk);
      chk("start_latency", rnd_start, 1);
   endtask

   task automatic rand_words(output elem_t w[16]);
      for (int k = 0; k < 16; k++) begin
         w[k] = elem_t'($urandom);
         if ($urandom_range(0, 7) == 0) w[k] = P;
      end
   endtask

   task automatic check_reset_outputs();
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_last",  out_last,  0);
      chk("rst_busy",      busy,      0);
      chk("rst_rnd_start", rnd_start, 0);
      chk("rst_rnd_index", rnd_index, 0);
      chk("rst_out_data",  out_data,  0);
      chk("rst_in_ready",  in_ready,  0);
   endtask

   initial begin
      #(400000);
      $display("FAIL watchdog_timeout checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

   initial begin
      elem_t w[16];
      int    n;
      for (int k = 0; k < 16; k++) spur_data[k] = elem_t'($urandom);

      // reset state
      #3;
      check_reset_outputs();
      @(posedge clk); @(posedge clk); #3;
      reset = 1'b0;
      @(negedge clk);
      chk("in_ready_before_clk", in_ready, 0);
      @(negedge clk);
      chk("in_ready_after_clk", in_ready, 1);
      chk("busy_idle", busy, 0);

      // ascending words, free-flowing output
      for (int k = 0; k < 16; k++) w[k] = elem_t'(k);
      load_perm(w, 1'b0, 1'b0);

      // values at and just below p
      w[0] = P;
      w[1] = P - 31'd1;
      for (int k = 2; k < 16; k++) w[k] = '0;
      load_perm(w, 1'b0, 1'b0);

      // alternating output backpressure
      or_mode = 1;
      rand_words(w);
      load_perm(w, 1'b0, 1'b0);

      // gapped input stream
      rand_words(w);
      load_perm(w, 1'b1, 1'b0);

      // stray rnd_valid pulses while loading and draining
      or_mode   = 2;
      spur_dren = 1'b1;
      rand_words(w);
      load_perm(w, 1'b1, 1'b1);
      rand_words(w);
      load_perm(w, 1'b0, 1'b1);

      // reset in WAIT of round 3, then a full permutation
      rand_words(w);
      load_perm(w, 1'b0, 1'b0);
      n = 0;
      while (!(rnd_start && rnd_index == 3'd3) && n < LIMIT) begin
         @(negedge clk);
         n++;
      end
      chk("reach_round3", n < LIMIT, 1);
      @(posedge clk); #2;
      reset = 1'b1;
      #1;
      check_reset_outputs();
      exp_q.delete();
      last_q.delete();
      exp_idx  = 0;
      pulses   = 0;
      hold_p   = 1'b0;
      exp_rs   = 1'b0;
      exp_ov   = 1'b0;
      suppress = 1'b1;
      @(posedge clk); #3;
      reset = 1'b0;
      @(negedge clk);
      chk("in_ready_post_rst", in_ready, 0);
      @(negedge clk);
      chk("in_ready_post_rst_clk", in_ready, 1);
      rand_words(w);
      load_perm(w, 1'b0, 1'b0);

      // random mix
      for (int r = 0; r < 4; r++) begin
         or_mode   = r % 3;
         spur_dren = 1'(r & 1);
         rand_words(w);
         load_perm(w, 1'(r >> 1), 1'(r & 1));
      end

      n = 0;
      while (exp_q.size() != 0 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk("drain_complete", exp_q.size(), 0);
      @(negedge clk);
      chk("idle_after_drain", busy, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
